ram_port_master: RTL and testbench
==================================

Name: ram_port_master

Overview:
- Single-clock initiator that drives the write and read ports of the dual-port asynchronous RAM: ram_add, data_in, wr_en, rd_en, clk_wr and clk_rd.
- Takes one request at a time over a valid/ready handshake and turns it into a fixed setup/strobe/hold sequence on the RAM pins.
- For reads, it samples the RAM's data_out after a programmable wait and returns it as a one-cycle response.
- It sits between system logic and the RAM, and generates the RAM strobes from the system clock.

Parameters:
DATA_W, 8, RAM data width
ADDR_W, 8, RAM address width
RD_WAIT, 1, clock cycles between the falling edge of clk_rd and data sampling (legal range 0..15)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse; rsp_data is valid
rsp_data  out  DATA_W  captured read data
ram_add  out  ADDR_W  to RAM ram_add
data_in  out  DATA_W  to RAM data_in
wr_en  out  1  to RAM wr_en
rd_en  out  1  to RAM rd_en
clk_wr  out  1  to RAM clk_wr (write strobe)
clk_rd  out  1  to RAM clk_rd (read strobe)
ram_data_out  in  DATA_W  from RAM data_out
busy  out  1  state is not IDLE
wr_cnt  out  16  completed writes, wraps 0xFFFF->0
rd_cnt  out  16  completed reads, wraps 0xFFFF->0

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All registered outputs = 0: ram_add, data_in, wr_en, rd_en, clk_wr, clk_rd, rsp_valid, rsp_data, wr_cnt, rd_cnt.
  - req_ready = 0 while rst is low.
- Output timing: all RAM-side outputs and rsp_* are registered, so strobes are glitch-free. req_ready = (state==IDLE) && rst. busy = (state!=IDLE).
- States: IDLE, SETUP, STROBE, HOLD, WAIT.
  - IDLE: accept a request on a rising edge where req_valid && req_ready. On acceptance, load ram_add <= req_addr. For a write, also load data_in <= req_wdata; for a read, data_in holds. Set wr_en <= req_we and rd_en <= !req_we. Go to SETUP.
  - SETUP (1 cycle): address, data and enable are stable. Next: STROBE; on entry, clk_wr <= we or clk_rd <= !we.
  - STROBE (1 cycle): the selected strobe is high. Next: HOLD; the strobe returns to 0 while the enable stays asserted.
  - HOLD (1 cycle):
    - Write: wr_en <= 0, wr_cnt increments, next state IDLE.
    - Read with RD_WAIT=0: sample, next state IDLE.
    - Read with RD_WAIT>0: load the wait counter, next state WAIT.
  - WAIT: rd_en stays high. Sample on the edge that ends the RD_WAIT-th WAIT cycle, then go to IDLE.
  - Sample edge: rsp_data <= ram_data_out, rsp_valid <= 1, rd_en <= 0, rd_cnt increments.
- rsp_valid is high for exactly one cycle; rsp_data holds until the next sample.
- Latency, counted from the acceptance edge:
  - Write: req_ready returns 3 cycles later.
  - Read: rsp_valid is high in the cycle starting 3+RD_WAIT edges after acceptance.
  - A new request may be accepted in the same cycle that rsp_valid is high.
- Exclusivity: wr_en/clk_wr and rd_en/clk_rd are never both active. The strobe not selected stays 0 for the whole transaction.
- Request sampling: req_* inputs are ignored when req_ready=0; they are sampled only on the acceptance edge.
- Reset mid-operation: the transaction is aborted immediately, strobes and enables drop asynchronously, and no rsp_valid or counter increment is produced.
- ram_add and data_in keep their last values in IDLE.

Test Plan:
- Reset: hold rst=0 with req_valid=1 -> all outputs 0 and req_ready=0. After release, req_ready=1 on the next cycle with no transaction started.
- Write 0xFF to address 1:
  - SETUP cycle: ram_add=1, data_in=0xFF, wr_en=1, clk_wr=0.
  - Next cycle: clk_wr=1.
  - Next cycle: clk_wr=0, wr_en=1.
  - Then wr_en=0 and req_ready=1; wr_cnt=1.
  - rd_en and clk_rd stay 0 throughout.
- Read address 1, RAM model returns 0xFF, RD_WAIT=1 -> rd_en high for 4 cycles, clk_rd high only in the STROBE cycle, rsp_valid pulses once 4 cycles after acceptance with rsp_data=0xFF, rd_cnt=1.
- Back-to-back: hold req_valid=1 with a write (0x5A to addr 3) followed by a read of addr 3 -> the read is accepted the cycle req_ready returns, with no overlap of wr_en and rd_en. rsp_data=0x5A.
- Sampling edge: the model changes ram_data_out from 0x11 to 0x22 one cycle after the sample edge -> rsp_data=0x11. Repeating with RD_WAIT=0 gives a response 3 cycles after acceptance.
- Abort and wrap: assert rst=0 during a read's STROBE cycle -> clk_rd and rd_en drop immediately, no rsp_valid, counters 0. Preload wr_cnt=0xFFFF via 65536 writes (or force) -> the next write gives wr_cnt=0.

Source files
------------

// File: rtl/ram_port_master.sv
// Single-clock initiator for a dual-port asynchronous RAM. Each accepted request
// becomes a registered setup/strobe/hold sequence; reads return a one-cycle response.
module ram_port_master #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic              rd_en,
  output logic              clk_wr,
  output logic              clk_rd,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT} state_t;

  // The wait counter counts down to zero, so it is loaded with one less than the wait.
  localparam logic [3:0] WAIT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  state_t     state_q;
  state_t     state_d;
  logic       op_we;
  logic [3:0] wait_cnt;

  logic accept;
  logic strobe_on;
  logic strobe_off;
  logic wr_done;
  logic sample;
  logic wait_load;
  logic wait_dec;

  function automatic logic [15:0] cnt_inc(input logic [15:0] v);
    return v + 16'd1;
  endfunction

  assign req_ready = (state_q == S_IDLE) && rst;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    strobe_on  = 1'b0;
    strobe_off = 1'b0;
    wr_done    = 1'b0;
    sample     = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        strobe_on = 1'b1;
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        strobe_off = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (op_we) begin
          wr_done = 1'b1;
          state_d = S_IDLE;
        end else if (RD_WAIT == 0) begin
          sample  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_load = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          sample  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin and response registers: every RAM-facing signal comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_we     <= 1'b0;
      wait_cnt  <= 4'd0;
      ram_add   <= '0;
      data_in   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      clk_wr    <= 1'b0;
      clk_rd    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      wr_cnt    <= 16'd0;
      rd_cnt    <= 16'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_we   <= req_we;
        ram_add <= req_addr;
        if (req_we) data_in <= req_wdata;
        wr_en   <= req_we;
        rd_en   <= !req_we;
      end
      if (strobe_on) begin
        clk_wr <= op_we;
        clk_rd <= !op_we;
      end
      if (strobe_off) begin
        clk_wr <= 1'b0;
        clk_rd <= 1'b0;
      end
      if (wr_done) begin
        wr_en  <= 1'b0;
        wr_cnt <= cnt_inc(wr_cnt);
      end
      if (wait_load)     wait_cnt <= WAIT_LOAD;
      else if (wait_dec) wait_cnt <= wait_cnt - 4'd1;
      if (sample) begin
        rsp_data  <= ram_data_out;
        rsp_valid <= 1'b1;
        rd_en     <= 1'b0;
        rd_cnt    <= cnt_inc(rd_cnt);
      end
    end
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: table vectors, random traffic against a memory
// scoreboard, and hand-written sequences for reset, back-to-back, sampling and wrap.
module tb_ram_port_master;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int RDW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, ram_add;
  logic [DW-1:0] req_wdata, rsp_data, data_in, ram_data_out;
  logic          rsp_valid, wr_en, rd_en, clk_wr, clk_rd, busy;
  logic [15:0]   wr_cnt, rd_cnt;

  logic          z_req_valid, z_req_ready, z_req_we;
  logic [AW-1:0] z_req_addr, z_ram_add;
  logic [DW-1:0] z_req_wdata, z_rsp_data, z_data_in, z_ram_out;
  logic          z_rsp_valid, z_wr_en, z_rd_en, z_clk_wr, z_clk_rd, z_busy;
  logic [15:0]   z_wr_cnt, z_rd_cnt;

  ram_port_master #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_add(ram_add), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .clk_wr(clk_wr),
    .clk_rd(clk_rd), .ram_data_out(ram_data_out), .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  ram_port_master #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data),
    .ram_add(z_ram_add), .data_in(z_data_in), .wr_en(z_wr_en), .rd_en(z_rd_en), .clk_wr(z_clk_wr),
    .clk_rd(z_clk_rd), .ram_data_out(z_ram_out), .busy(z_busy), .wr_cnt(z_wr_cnt), .rd_cnt(z_rd_cnt)
  );

  // Asynchronous RAM model with an override used to move data_out at chosen times.
  logic [DW-1:0] mem [256];
  logic          ovr_en;
  logic [DW-1:0] ovr_val;
  always @(posedge clk_wr) if (wr_en) mem[ram_add] <= data_in;
  assign ram_data_out = ovr_en ? ovr_val : mem[ram_add];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr, exp_rd;
  logic [7:0]  exp_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk)
    if (rst === 1'b1)
      check("exclusive", 32'({(wr_en | clk_wr) & (rd_en | clk_rd),
                              (z_wr_en | z_clk_wr) & (z_rd_en | z_clk_rd)}), 32'(0));

  // One transaction: expected pin pattern per cycle after acceptance comes from
  // the latency rules; req_* are scrambled while busy and must be ignored.
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rsp, input string tag);
    int         waited;
    int         lat;
    logic [6:0] exp_pins;
    waited    = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      check({tag, "_ready_timeout"}, 32'(req_ready), 32'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (we) begin
      ref_mem[addr] = wd;
      exp_din       = wd;
      exp_wr        = exp_wr + 16'd1;
    end else begin
      exp_rd = exp_rd + 16'd1;
    end
    lat = we ? 3 : 3 + RDW;
    for (int k = 1; k <= lat + 1; k++) begin
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      @(negedge clk);
      exp_pins = {we && k <= 3, we && k == 2, !we && k <= lat, !we && k == 2,
                  !we && k == lat + 1, k == lat + 1, k <= lat};
      check({tag, "_pins"}, 32'({wr_en, clk_wr, rd_en, clk_rd, rsp_valid, req_ready, busy}),
            32'(exp_pins));
      check({tag, "_ram_add"}, 32'(ram_add), 32'(addr));
      check({tag, "_data_in"}, 32'(data_in), 32'(exp_din));
      if (k == lat + 1) req_valid = 1'b0;
    end
    if (!we) check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_rsp));
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rsp;
  } vec_t;

  initial begin
    vec_t       vecs [9];
    int         lat;
    logic [7:0] a;
    logic [7:0] d;
    vecs[0] = '{we: 1'b1, addr: 8'h01, wdata: 8'hFF, exp_rsp: 8'h00};
    vecs[1] = '{we: 1'b0, addr: 8'h01, wdata: 8'h00, exp_rsp: 8'hFF};
    vecs[2] = '{we: 1'b1, addr: 8'h80, wdata: 8'h00, exp_rsp: 8'h00};
    vecs[3] = '{we: 1'b1, addr: 8'hFF, wdata: 8'hA5, exp_rsp: 8'h00};
    vecs[4] = '{we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rsp: 8'hA5};
    vecs[5] = '{we: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rsp: 8'h00};
    vecs[6] = '{we: 1'b1, addr: 8'h00, wdata: 8'h3C, exp_rsp: 8'h00};
    vecs[7] = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rsp: 8'h3C};
    vecs[8] = '{we: 1'b0, addr: 8'h01, wdata: 8'h00, exp_rsp: 8'hFF};

    exp_wr = 16'd0; exp_rd = 16'd0; exp_din = 8'h00;
    rst = 1'b0; ovr_en = 1'b0; ovr_val = 8'h00;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 8'h34;
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 8'h07; z_req_wdata = 8'h44; z_ram_out = 8'h00;

    // Reset held with a request pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'({wr_en, rd_en, clk_wr, clk_rd, rsp_valid, busy, req_ready}), 32'(0));
    check("reset_data", 32'({ram_add, data_in, rsp_data}), 32'(0));
    check("reset_cnt", {wr_cnt, rd_cnt}, 32'(0));
    check("reset_z", 32'({z_wr_en, z_rd_en, z_clk_wr, z_clk_rd, z_rsp_valid, z_busy, z_req_ready,
                          z_ram_add, z_data_in, z_wr_cnt}), 32'(0));
    req_valid = 1'b0; z_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'(1));
    @(negedge clk);
    check("idle_after_reset", 32'({busy, wr_en, rd_en, z_busy}), 32'(0));

    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rsp, $sformatf("vec%0d", i));

    // Back-to-back: request held valid across the write, read queued behind it
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h03; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 8'hC3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("b2b_ready", 32'(req_ready), 32'(k == 4));
      check("b2b_en", 32'({wr_en, rd_en}), 32'(k <= 3 ? 2'b10 : 2'b00));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_mem[3] = 8'h5A; exp_din = 8'h5A;
    exp_wr = exp_wr + 16'd1; exp_rd = exp_rd + 16'd1;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'(5));
    check("b2b_rsp", 32'(rsp_data), 32'h5A);
    check("b2b_data_in", 32'(data_in), 32'h5A);
    check("b2b_cnt", {wr_cnt, rd_cnt}, {exp_wr, exp_rd});

    // Sampling edge: data_out is 0x33 before, 0x11 at, 0x22 after the sample edge
    ovr_en = 1'b1; ovr_val = 8'h33;
    fork
      do_txn(1'b0, 8'h01, 8'h00, 8'h11, "sample_edge");
      begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 ovr_val = 8'h11;
        @(posedge clk);
        #1 ovr_val = 8'h22;
      end
    join
    @(negedge clk);
    check("rsp_single_pulse", 32'(rsp_valid), 32'(0));
    check("rsp_hold", 32'(rsp_data), 32'h11);
    ovr_en = 1'b0;

    for (int i = 0; i < 16; i++) do_txn(1'b1, 8'(i), 8'($urandom), 8'h00, "fill");
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_txn(1'b1, a, d, 8'h00, "rnd_wr");
      else                           do_txn(1'b0, a, 8'h00, ref_mem[a], "rnd_rd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort a read during its strobe cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h01;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_setup", 32'({rd_en, clk_rd}), 32'(2'b10));
    @(negedge clk);
    check("abort_strobe", 32'({rd_en, clk_rd}), 32'(2'b11));
    #1 rst = 1'b0;
    #1;
    check("abort_drop", 32'({rd_en, clk_rd, wr_en, clk_wr, busy, req_ready}), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", 32'({rsp_valid, rd_en}), 32'(0));
      check("abort_cnt", {wr_cnt, rd_cnt}, 32'(0));
    end
    rst = 1'b1;
    exp_wr = 16'd0; exp_rd = 16'd0; exp_din = 8'h00;
    @(negedge clk);
    check("abort_after", 32'({busy, rsp_valid, req_ready}), 32'(3'b001));

    // RD_WAIT=0 instance: response three edges after acceptance
    z_ram_out = 8'h33; z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 8'h07;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 3 || k == 4) begin
        @(posedge clk); #1;
        z_ram_out = (k == 3) ? 8'h11 : 8'h22;
      end
      @(negedge clk);
      check("z_pins", 32'({z_wr_en, z_clk_wr, z_rd_en, z_clk_rd, z_rsp_valid, z_req_ready}),
            32'({2'b00, k <= 3, k == 2, k == 4, k >= 4}));
      check("z_ram_add", 32'(z_ram_add), 32'h07);
    end
    check("z_rsp_data", 32'(z_rsp_data), 32'h11);
    check("z_rd_cnt", 32'(z_rd_cnt), 32'(1));

    // Write counter wrap from 0xFFFF
    @(posedge clk); #1;
    force dut.wr_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.wr_cnt;
    @(negedge clk);
    check("wrap_preload", 32'(wr_cnt), 32'hFFFF);
    exp_wr = 16'hFFFF;
    do_txn(1'b1, 8'h09, 8'h99, 8'h00, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
